// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the 8N1 UART transmitter.
//   tx_state_t : frame sequencer states
//   DATA_BITS  : data bits per frame
//   MIN_DIV    : shortest legal bit length in clocks
package uart_tx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam int DATA_BITS = 8;
    localparam int MIN_DIV   = 2;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered occupancy counter.
//   clk, reset : clock, synchronous active-high reset (empties the FIFO)
//   push       : write wr_data when not full
//   wr_data    : write data
//   pop        : drop the head entry when not empty
//   rd_data    : head entry, valid combinationally whenever not empty
//   full/empty : occupancy flags, derived from level only
//   level      : number of stored entries (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                level <= level + LW'(1);
            end else if (!do_push && do_pop) begin
                level <= level - LW'(1);
            end
        end
    end

endmodule

// File: rtl/uart_tx_stream.sv
// 8N1 UART transmitter fed from a small byte FIFO.
//   clk, reset  : clock, synchronous active-high reset
//   cfg_div     : clocks per bit (0 and 1 behave as 2)
//   cfg_div_we  : load cfg_div into the divider register
//   in_data     : byte to send, accepted when in_valid && in_ready
//   in_valid    : in_data is valid
//   in_ready    : FIFO not full
//   ser_tx      : serial line, idle high, driven from a flop
//   busy        : frame in progress or bytes queued
//   fifo_level  : FIFO occupancy
module uart_tx_stream
    import uart_tx_pkg::*;
#(
    parameter int DEFAULT_DIV = 104,
    parameter int DIV_WIDTH   = 16,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DIV_WIDTH-1:0]          cfg_div,
    input  logic                          cfg_div_we,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          ser_tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    tx_state_t            state, state_n;
    logic [DIV_WIDTH-1:0] div_reg;
    logic [DIV_WIDTH-1:0] eff_div;
    logic [DIV_WIDTH-1:0] bitlen, bitlen_n;
    logic [DIV_WIDTH-1:0] cnt, cnt_n;
    logic [2:0]           idx, idx_n;
    logic [7:0]           shift, shift_n;
    logic                 tx_n;
    logic                 load;
    logic                 push_acc;
    logic [LW-1:0]        level_n;
    logic [7:0]           fifo_rd_data;
    logic                 fifo_full;
    logic                 fifo_empty;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (in_valid),
        .wr_data (in_data),
        .pop     (load),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign in_ready = !fifo_full;
    assign push_acc = in_valid && in_ready;
    assign eff_div  = (div_reg < DIV_WIDTH'(MIN_DIV)) ? DIV_WIDTH'(MIN_DIV) : div_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            div_reg <= DIV_WIDTH'(DEFAULT_DIV);
        end else if (cfg_div_we) begin
            div_reg <= cfg_div;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            bitlen <= DIV_WIDTH'(MIN_DIV);
            cnt    <= '0;
            idx    <= '0;
            shift  <= '0;
            ser_tx <= 1'b1;
            busy   <= 1'b0;
        end else begin
            state  <= state_n;
            bitlen <= bitlen_n;
            cnt    <= cnt_n;
            idx    <= idx_n;
            shift  <= shift_n;
            ser_tx <= tx_n;
            busy   <= (state_n != IDLE) || (level_n != '0);
        end
    end

    // FIFO occupancy after this edge, so busy lines up with state and level.
    always_comb begin
        level_n = fifo_level;
        if (push_acc && !load) begin
            level_n = fifo_level + LW'(1);
        end else if (!push_acc && load) begin
            level_n = fifo_level - LW'(1);
        end
    end

    // The line value for the next clock is computed here and registered,
    // so ser_tx changes exactly on the edge that starts each bit.
    always_comb begin
        state_n  = state;
        bitlen_n = bitlen;
        cnt_n    = cnt;
        idx_n    = idx;
        shift_n  = shift;
        tx_n     = ser_tx;
        load     = 1'b0;

        case (state)
            IDLE: begin
                tx_n = 1'b1;
                load = !fifo_empty;
            end
            START: begin
                if (cnt == '0) begin
                    state_n = DATA;
                    cnt_n   = bitlen - DIV_WIDTH'(1);
                    idx_n   = '0;
                    tx_n    = shift[0];
                end else begin
                    cnt_n = cnt - DIV_WIDTH'(1);
                end
            end
            DATA: begin
                if (cnt == '0) begin
                    cnt_n = bitlen - DIV_WIDTH'(1);
                    if (idx == 3'(DATA_BITS - 1)) begin
                        state_n = STOP;
                        tx_n    = 1'b1;
                    end else begin
                        shift_n = {1'b0, shift[7:1]};
                        idx_n   = idx + 3'd1;
                        tx_n    = shift[1];
                    end
                end else begin
                    cnt_n = cnt - DIV_WIDTH'(1);
                end
            end
            STOP: begin
                if (cnt == '0) begin
                    if (!fifo_empty) begin
                        load = 1'b1;
                    end else begin
                        state_n = IDLE;
                        tx_n    = 1'b1;
                    end
                end else begin
                    cnt_n = cnt - DIV_WIDTH'(1);
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
            end
        endcase

        // Pop from IDLE or from the last STOP clock: the divider is frozen
        // into bitlen here so later cfg writes leave this frame alone.
        if (load) begin
            state_n  = START;
            shift_n  = fifo_rd_data;
            bitlen_n = eff_div;
            cnt_n    = eff_div - DIV_WIDTH'(1);
            tx_n     = 1'b0;
        end
    end

endmodule

// File: doc/uart_tx_stream.md
Name: uart_tx_stream

Overview:
Synthesizable 8N1 UART transmitter with a small input FIFO. It is the transmit end of the serial link the testbench decodes on ser_tx: idle-high line, start bit low, 8 data bits LSB first, one stop bit high.
- Used by ctrlsoc as the console TX path.
- Also usable by benches as a stimulus source driving ser_rx.
- Bit timing comes from a runtime divider. The default is 104 clocks per bit, which gives 115200 baud from 12 MHz.

Parameters:
DEFAULT_DIV, 104, clocks per bit used when cfg_div_we has never been asserted since reset
DIV_WIDTH, 16, width of the divider register and bit counter
FIFO_DEPTH, 4, byte FIFO depth; must be a power of two, at least 2

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
cfg_div  input  DIV_WIDTH  new clocks-per-bit value
cfg_div_we  input  1  when high, load cfg_div into the divider register on this edge
in_data  input  8  byte to transmit
in_valid  input  1  in_data is valid
in_ready  output  1  FIFO can accept a byte (not full)
ser_tx  output  1  serial line, idle high
busy  output  1  high while a frame is in progress or the FIFO is non-empty
fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (synchronous, active-high): ser_tx=1, busy=0, fifo_level=0, in_ready=1, FSM=IDLE, divider=DEFAULT_DIV. Reset asserted mid-frame aborts the frame, drives ser_tx=1 from the next edge and empties the FIFO. No partial bits follow.
- Divider: effective bit length is max(div,2) clocks; values 0 and 1 are treated as 2. The divider is latched into a frame-local register when a byte is popped. A cfg_div_we during a frame does not affect that frame.
- Push: a byte is accepted on an edge where in_valid && in_ready. in_ready = (fifo_level != FIFO_DEPTH), combinational from the level only.
  - When full, no push occurs even if a pop happens on the same edge.
  - in_data is ignored when not accepted.
- Pop: occurs on an edge where FSM is IDLE, or in STOP on its final clock, and the FIFO is non-empty.
  - Push and pop on the same edge leave fifo_level unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: ser_tx=1. If FIFO non-empty, pop -> START, ser_tx=0 from that edge.
  - START: hold 0 for bitlen clocks -> DATA.
  - DATA: send shift[0], shift right each bitlen clocks, 8 bits -> STOP.
  - STOP: ser_tx=1 for bitlen clocks. Then pop -> START if FIFO non-empty (back-to-back, no idle gap), else -> IDLE.
- Latency: a byte pushed at edge k into an empty FIFO with FSM IDLE is popped at edge k+1; ser_tx falls after edge k+1. Frame length is exactly 10*bitlen clocks.
- Counter: one bit counter counts bitlen-1 down to 0, plus a 3-bit data-bit index. No arithmetic overflow: the counter is DIV_WIDTH wide, matching the divider.
- busy = (FSM != IDLE) || (fifo_level != 0), registered from state/level.
- ser_tx is driven from a flop (glitch-free).

Decomposition:
- Package uart_tx_pkg:
  - state enum tx_state_t {IDLE, START, DATA, STOP}
  - localparams DATA_BITS=8, MIN_DIV=2
- Sub-module sync_fifo (parameters WIDTH, DEPTH):
  - synchronous, same reset, registered level counter
  - ports push/pop/full/empty/level
  - read data valid combinationally from the head entry
- The top holds the divider register, FSM, shifter and bit counter.

Test Plan:
- div=104, push 0x55 at edge k -> ser_tx low from edge k+1 for 104 clocks. Data 1,0,1,0,1,0,1,0 (LSB first, 104 clocks each), stop high 104 clocks. A UART sampler at 1.5-bit offset decodes 0x55. busy drops at k+1+1040.
- div=104, push 6 bytes 0x00..0x05 back-to-back -> accepted on edges k..k+4 and in_ready=0 after k+4 (fifo_level=4). Byte 0x05 is accepted on the edge of the next pop, k+1041. Start falling edges are exactly 1040 clocks apart with no idle gap; the decoded sequence is 00..05.
- cfg_div=0 with cfg_div_we, push 0xA3 -> 2-clock bits, frame 20 clocks. Bits after start: 1,1,0,0,0,1,0,1, then stop.
- Mid-frame cfg_div_we to 50 during a div=104 frame containing 0xFF -> current frame keeps 104-clock bits. The next queued byte uses 50-clock bits.
- Reset asserted in DATA state of byte 0x0F with 2 bytes queued -> ser_tx=1, fifo_level=0, busy=0, in_ready=1 from the next edge. No further start bit appears for 2000 clocks with in_valid=0.
- Simultaneous push and pop (FIFO holding 2, STOP final clock, in_valid=1) -> fifo_level stays 2 and the new byte is transmitted in order.
